// File: rtl/pc_mem_sp_pkg.sv
// Shared opcode constants, FSM state encoding and helpers for the
// PC / memory / IR / SP control sequencer.
package pc_mem_sp_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'h1;
    localparam logic [3:0] OP_PUSH = 4'h2;
    localparam logic [3:0] OP_POP  = 4'h3;
    localparam logic [3:0] OP_CALL = 4'h4;
    localparam logic [3:0] OP_RET  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_JMP_PC  = 4'd2,
        S_PUSH_SP = 4'd3,
        S_PUSH_WR = 4'd4,
        S_POP_RD  = 4'd5,
        S_POP_SP  = 4'd6,
        S_CALL_SP = 4'd7,
        S_CALL_WR = 4'd8,
        S_CALL_PC = 4'd9,
        S_RET_RD  = 4'd10,
        S_RET_SP  = 4'd11,
        S_RET_PC  = 4'd12,
        S_HALT    = 4'd13,
        S_FAULT   = 4'd14
    } state_t;

    // States that sit waiting for the memory handshake (LMC).
    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH)   || (s == S_PUSH_WR) || (s == S_POP_RD) ||
               (s == S_CALL_WR) || (s == S_RET_RD);
    endfunction

endpackage

// File: rtl/pc_mem_sp_controller_mem_watchdog.sv
// Memory-cycle watchdog: counts stalled cycles in a wait state and flags
// expiry combinationally on the last allowed stalled cycle.
module mem_watchdog #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam bit WD_ON = (MEM_TIMEOUT != 0);
    localparam logic [TO_W-1:0] LIMIT = WD_ON ? TO_W'(MEM_TIMEOUT - 1) : '0;

    logic [TO_W-1:0] count_reg;

    // Stall counter; held at zero when the watchdog is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr || !WD_ON) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + TO_W'(1);
        end
    end

    generate
        if (WD_ON) begin : g_wd_on
            // Expiry only on a stalled cycle, so a completing access wins.
            assign expire = en && (count_reg == LIMIT);
        end else begin : g_wd_off
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/pc_mem_sp_controller.sv
// Multicycle control FSM for the PC / memory / IR / SP datapath.
// Fetch, decode, then a per-opcode micro-sequence; memory waits are
// guarded by a watchdog that traps to a sticky FAULT state.
module pc_mem_sp_controller
    import pc_mem_sp_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] Op,
    input  logic       LMC,
    output logic       PCW,
    output logic       IW,
    output logic       MW,
    output logic       MDRW,
    output logic       SPW,
    output logic       SPIorD,
    output logic       MSrc,
    output logic       IorD,
    output logic       Jump,
    output logic       MemToPC,
    output logic       Halted,
    output logic       Fault,
    output logic       IllegalOp
);

    state_t state_reg, state_next;
    logic   wd_clr, wd_en, wd_expire;

    // Watchdog counts stalled cycles and restarts on every state change.
    assign wd_en  = is_mem_wait(state_reg) && !LMC;
    assign wd_clr = (state_next != state_reg);

    mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TO_W       (TO_W)
    ) u_wd (
        .clk   (CLK),
        .rst   (RESET),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_expire)
    );

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: opcode dispatch and memory-handshake waits.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:   if (LMC) state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_NOP:  state_next = S_FETCH;
                    OP_JMP:  state_next = S_JMP_PC;
                    OP_PUSH: state_next = S_PUSH_SP;
                    OP_POP:  state_next = S_POP_RD;
                    OP_CALL: state_next = S_CALL_SP;
                    OP_RET:  state_next = S_RET_RD;
                    OP_HALT: state_next = S_HALT;
                    default: state_next = S_FETCH;
                endcase
            end
            S_JMP_PC:  state_next = S_FETCH;
            S_PUSH_SP: state_next = S_PUSH_WR;
            S_PUSH_WR: if (LMC) state_next = S_FETCH;
            S_POP_RD:  if (LMC) state_next = S_POP_SP;
            S_POP_SP:  state_next = S_FETCH;
            S_CALL_SP: state_next = S_CALL_WR;
            S_CALL_WR: if (LMC) state_next = S_CALL_PC;
            S_CALL_PC: state_next = S_FETCH;
            S_RET_RD:  if (LMC) state_next = S_RET_SP;
            S_RET_SP:  state_next = S_RET_PC;
            S_RET_PC:  state_next = S_FETCH;
            S_HALT:    state_next = S_HALT;
            S_FAULT:   state_next = S_FAULT;
            default:   state_next = S_FETCH;
        endcase
        // Only asserted on a stalled wait cycle, so completion takes priority.
        if (wd_expire) state_next = S_FAULT;
    end

    // Output decode: Moore per state, except IW/MDRW follow LMC in read waits;
    // everything is forced low while reset is held.
    always_comb begin
        PCW       = 1'b0;
        IW        = 1'b0;
        MW        = 1'b0;
        MDRW      = 1'b0;
        SPW       = 1'b0;
        SPIorD    = 1'b0;
        MSrc      = 1'b0;
        IorD      = 1'b0;
        Jump      = 1'b0;
        MemToPC   = 1'b0;
        Halted    = 1'b0;
        Fault     = 1'b0;
        IllegalOp = 1'b0;
        case (state_reg)
            S_FETCH:   IW = LMC;
            S_DECODE: begin
                PCW       = 1'b1;
                IllegalOp = !(Op inside {OP_NOP, OP_JMP, OP_PUSH, OP_POP,
                                         OP_CALL, OP_RET, OP_HALT});
            end
            S_JMP_PC:  begin PCW = 1'b1; Jump = 1'b1; end
            S_PUSH_SP: begin SPW = 1'b1; SPIorD = 1'b1; end
            S_PUSH_WR: begin MW = 1'b1; IorD = 1'b1; end
            S_POP_RD:  begin IorD = 1'b1; MDRW = LMC; end
            S_POP_SP:  SPW = 1'b1;
            S_CALL_SP: begin SPW = 1'b1; SPIorD = 1'b1; end
            S_CALL_WR: begin MW = 1'b1; IorD = 1'b1; MSrc = 1'b1; end
            S_CALL_PC: begin PCW = 1'b1; Jump = 1'b1; end
            S_RET_RD:  begin IorD = 1'b1; MDRW = LMC; end
            S_RET_SP:  SPW = 1'b1;
            S_RET_PC:  begin PCW = 1'b1; MemToPC = 1'b1; end
            S_HALT:    Halted = 1'b1;
            S_FAULT:   Fault = 1'b1;
            default:   ;
        endcase
        if (RESET) begin
            PCW       = 1'b0;
            IW        = 1'b0;
            MW        = 1'b0;
            MDRW      = 1'b0;
            SPW       = 1'b0;
            SPIorD    = 1'b0;
            MSrc      = 1'b0;
            IorD      = 1'b0;
            Jump      = 1'b0;
            MemToPC   = 1'b0;
            Halted    = 1'b0;
            Fault     = 1'b0;
            IllegalOp = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_mem_sp_controller.sv
// Bench for pc_mem_sp_controller: directed vector table, hand-written
// halt / async-reset sequences, and random traffic against an
// instruction-level reference model.
module tb_pc_mem_sp_controller;

    localparam int MT = 4;

    // Output vector bit positions {PCW,IW,MW,MDRW,SPW,SPIorD,MSrc,IorD,Jump,MemToPC,Halted,Fault,IllegalOp}
    localparam logic [12:0] E_PCW  = 13'h1000;
    localparam logic [12:0] E_IW   = 13'h0800;
    localparam logic [12:0] E_MW   = 13'h0400;
    localparam logic [12:0] E_MDRW = 13'h0200;
    localparam logic [12:0] E_SPW  = 13'h0100;
    localparam logic [12:0] E_SPD  = 13'h0080;
    localparam logic [12:0] E_MSRC = 13'h0040;
    localparam logic [12:0] E_IORD = 13'h0020;
    localparam logic [12:0] E_JMP  = 13'h0010;
    localparam logic [12:0] E_M2PC = 13'h0008;
    localparam logic [12:0] E_HLT  = 13'h0004;
    localparam logic [12:0] E_FLT  = 13'h0002;
    localparam logic [12:0] E_ILL  = 13'h0001;
    localparam logic [12:0] E_NONE = 13'h0000;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] Op;
    logic       LMC;
    logic PCW, IW, MW, MDRW, SPW, SPIorD, MSrc, IorD, Jump, MemToPC, Halted, Fault, IllegalOp;
    logic [12:0] outs;

    int checks = 0;
    int errors = 0;

    pc_mem_sp_controller #(.MEM_TIMEOUT(MT), .TO_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .Op(Op), .LMC(LMC),
        .PCW(PCW), .IW(IW), .MW(MW), .MDRW(MDRW), .SPW(SPW), .SPIorD(SPIorD),
        .MSrc(MSrc), .IorD(IorD), .Jump(Jump), .MemToPC(MemToPC),
        .Halted(Halted), .Fault(Fault), .IllegalOp(IllegalOp)
    );

    assign outs = {PCW, IW, MW, MDRW, SPW, SPIorD, MSrc, IorD, Jump, MemToPC, Halted, Fault, IllegalOp};

    always #5 CLK = ~CLK;

    // ---------------- reference model (instruction level) ----------------
    typedef struct {
        logic [12:0] o;
        bit          w;   // waits for LMC
        bit          rd;  // MDRW follows LMC
    } mstep_t;

    int          m_mode;   // 0 running, 1 halted, 2 faulted
    int          m_phase;  // 0 fetch, 1 decode, 2+ micro-step index + 2
    logic [3:0]  m_op;
    int          m_wcnt;

    function automatic int seq_len(logic [3:0] op);
        case (op)
            4'h1: return 1;
            4'h2: return 2;
            4'h3: return 2;
            4'h4: return 3;
            4'h5: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic mstep_t micro(logic [3:0] op, int k);
        mstep_t s;
        s.o = E_NONE; s.w = 1'b0; s.rd = 1'b0;
        case (op)
            4'h1: s.o = E_PCW | E_JMP;
            4'h2: if (k == 0) s.o = E_SPW | E_SPD;
                  else begin s.o = E_MW | E_IORD; s.w = 1'b1; end
            4'h3: if (k == 0) begin s.o = E_IORD; s.w = 1'b1; s.rd = 1'b1; end
                  else s.o = E_SPW;
            4'h4: if (k == 0) s.o = E_SPW | E_SPD;
                  else if (k == 1) begin s.o = E_MW | E_IORD | E_MSRC; s.w = 1'b1; end
                  else s.o = E_PCW | E_JMP;
            4'h5: if (k == 0) begin s.o = E_IORD; s.w = 1'b1; s.rd = 1'b1; end
                  else if (k == 1) s.o = E_SPW;
                  else s.o = E_PCW | E_M2PC;
            default: ;
        endcase
        return s;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_op = 4'h0; m_wcnt = 0;
    endtask

    function automatic logic [12:0] model_out(logic [3:0] op, bit lmc);
        mstep_t s;
        if (m_mode == 1) return E_HLT;
        if (m_mode == 2) return E_FLT;
        if (m_phase == 0) return lmc ? E_IW : E_NONE;
        if (m_phase == 1) return E_PCW | ((op >= 4'h6 && op <= 4'hE) ? E_ILL : E_NONE);
        s = micro(m_op, m_phase - 2);
        return s.o | ((s.rd && lmc) ? E_MDRW : E_NONE);
    endfunction

    task automatic model_step(logic [3:0] op, bit lmc);
        bit is_wait;
        if (m_mode != 0) return;
        is_wait = (m_phase == 0) || (m_phase >= 2 && micro(m_op, m_phase - 2).w);
        if (is_wait && !lmc) begin
            if (m_wcnt == MT - 1) m_mode = 2;
            else m_wcnt++;
            return;
        end
        m_wcnt = 0;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_op = op;
            if (op == 4'hF) m_mode = 1;
            else if (seq_len(op) == 0) m_phase = 0;
            else m_phase = 2;
        end else if (m_phase - 1 < seq_len(m_op)) begin
            m_phase++;
        end else begin
            m_phase = 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, int idx, logic [12:0] act, logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s #%0d outs=%013b expected=%013b", name, idx, act, exp);
        end
    endtask

    // One clock: drive at negedge, check just after, advance model on posedge.
    task automatic cycle(bit r, logic [3:0] op, bit lmc, bit use_tab,
                         logic [12:0] tab, string name, int idx);
        logic [12:0] exp;
        RESET = r; Op = op; LMC = lmc;
        #1;
        if (r)            exp = E_NONE;
        else if (use_tab) exp = tab;
        else              exp = model_out(op, lmc);
        check(name, idx, outs, exp);
        @(posedge CLK);
        if (r) model_reset();
        else   model_step(op, lmc);
        @(negedge CLK);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          r;
        logic [3:0]  op;
        bit          lmc;
        logic [12:0] exp;
    } vec_t;

    vec_t tab[$];

    task automatic add(bit r, logic [3:0] op, bit lmc, logic [12:0] exp);
        vec_t v;
        v.r = r; v.op = op; v.lmc = lmc; v.exp = exp;
        tab.push_back(v);
    endtask

    initial begin
        RESET = 1'b1; Op = 4'h2; LMC = 1'b1;
        model_reset();

        // reset with LMC=1, Op=2
        add(1, 4'h2, 1, E_NONE);
        // NOP: fetch, decode
        add(0, 4'h0, 1, E_IW);          add(0, 4'h0, 1, E_PCW);
        // JMP
        add(0, 4'h1, 1, E_IW);          add(0, 4'h1, 1, E_PCW);
        add(0, 4'h1, 1, E_PCW | E_JMP);
        // PUSH with 3 stall cycles
        add(0, 4'h2, 1, E_IW);          add(0, 4'h2, 1, E_PCW);
        add(0, 4'h2, 1, E_SPW | E_SPD);
        add(0, 4'h2, 0, E_MW | E_IORD); add(0, 4'h2, 0, E_MW | E_IORD);
        add(0, 4'h2, 0, E_MW | E_IORD); add(0, 4'h2, 1, E_MW | E_IORD);
        // POP
        add(0, 4'h3, 1, E_IW);          add(0, 4'h3, 1, E_PCW);
        add(0, 4'h3, 1, E_IORD | E_MDRW); add(0, 4'h3, 1, E_SPW);
        // CALL
        add(0, 4'h4, 1, E_IW);          add(0, 4'h4, 1, E_PCW);
        add(0, 4'h4, 1, E_SPW | E_SPD); add(0, 4'h4, 1, E_MW | E_IORD | E_MSRC);
        add(0, 4'h4, 1, E_PCW | E_JMP);
        // RET
        add(0, 4'h5, 1, E_IW);          add(0, 4'h5, 1, E_PCW);
        add(0, 4'h5, 1, E_IORD | E_MDRW); add(0, 4'h5, 1, E_SPW);
        add(0, 4'h5, 1, E_PCW | E_M2PC);
        // illegal opcode 9
        add(0, 4'h9, 1, E_IW);          add(0, 4'h9, 1, E_PCW | E_ILL);
        // fetch never completes: fault on the 5th cycle
        add(0, 4'h0, 0, E_NONE); add(0, 4'h0, 0, E_NONE);
        add(0, 4'h0, 0, E_NONE); add(0, 4'h0, 0, E_NONE);
        add(0, 4'h0, 1, E_FLT);  add(0, 4'h1, 0, E_FLT);
        // reset, then LMC arrives on the 4th wait cycle: no fault
        add(1, 4'h0, 0, E_NONE);
        add(0, 4'h0, 0, E_NONE); add(0, 4'h0, 0, E_NONE); add(0, 4'h0, 0, E_NONE);
        add(0, 4'h0, 1, E_IW);   add(0, 4'h0, 1, E_PCW);
        // HALT
        add(0, 4'hF, 1, E_IW);   add(0, 4'hF, 1, E_PCW);
        add(0, 4'hF, 1, E_HLT);

        @(negedge CLK);
        for (int i = 0; i < tab.size(); i++)
            cycle(tab[i].r, tab[i].op, tab[i].lmc, 1'b1, tab[i].exp, "table", i);

        // HALT is sticky for 20 cycles regardless of Op / LMC
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 4'($urandom_range(0, 15)), i[0], 1'b1, E_HLT, "halt_hold", i);

        // Async reset in the middle of a stalled CALL write
        cycle(1'b1, 4'h0, 1'b0, 1'b1, E_NONE, "rst_call", 0);
        cycle(1'b0, 4'h4, 1'b1, 1'b1, E_IW, "rst_call", 1);
        cycle(1'b0, 4'h4, 1'b1, 1'b1, E_PCW, "rst_call", 2);
        cycle(1'b0, 4'h4, 1'b1, 1'b1, E_SPW | E_SPD, "rst_call", 3);
        cycle(1'b0, 4'h4, 1'b0, 1'b1, E_MW | E_IORD | E_MSRC, "rst_call", 4);
        Op = 4'h4; LMC = 1'b0;
        #1;
        check("call_wr_stall", 0, outs, E_MW | E_IORD | E_MSRC);
        #1;
        RESET = 1'b1;
        #1;
        check("async_rst_mid_cycle", 0, outs, E_NONE);
        @(posedge CLK);
        model_reset();
        @(negedge CLK);
        cycle(1'b0, 4'h0, 1'b1, 1'b1, E_IW, "restart_fetch", 0);
        cycle(1'b0, 4'h0, 1'b1, 1'b1, E_PCW, "restart_fetch", 1);

        // Randomized traffic against the reference model
        cycle(1'b1, 4'h0, 1'b0, 1'b0, E_NONE, "rand", 0);
        for (int i = 1; i < 3000; i++) begin
            bit r;
            bit l;
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 70);
            cycle(r, 4'($urandom_range(0, 15)), l, 1'b0, E_NONE, "rand", i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
